// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder for the Memory stage.
// Accepts one aligned load/store per request, stalls the pipeline, then pulses doneM.
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_reqM,
    input  logic        mem_writeM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] addrM,
    input  logic [31:0] write_dataM,
    output logic        stallM,
    output logic [31:0] read_dataM,
    output logic        doneM,
    output logic        misalignM
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_next;

    logic [3:0]    cnt, cnt_next;
    logic          write_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH];

    logic        f3_legal, aligned, accept;
    logic [31:0] word, load_val, store_word;
    logic [3:0]  lane_en;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Upper address bits alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addrM[31:AW+2];

    always_comb begin
        f3_legal = 1'b0;
        case (funct3M)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !mem_writeM;
            default:                f3_legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3M[1:0])
            2'b01:   aligned = !addrM[0];
            2'b10:   aligned = (addrM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept = mem_reqM && f3_legal && aligned;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stallM     = 1'b0;
        doneM      = 1'b0;
        misalignM  = 1'b0;
        // Outputs are held low for the whole reset interval, not just after the edge.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        stallM     = 1'b1;
                        cnt_next   = CNT_INIT;
                        state_next = (LATENCY == 1) ? DONE : WAIT;
                    end else if (mem_reqM) begin
                        misalignM = 1'b1;
                    end
                end
                WAIT: begin
                    stallM   = 1'b1;
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) state_next = DONE;
                end
                DONE: begin
                    doneM      = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && accept) begin
                write_q  <= mem_writeM;
                funct3_q <= funct3M;
                addr_q   <= addrM[AW+1:0];
                wdata_q  <= write_dataM;
            end
            if (state == DONE && !write_q) rdata_q <= load_val;
        end
    end

    always_comb begin
        word = mem[addr_q[AW+1:2]];
        case (addr_q[1:0])
            2'b00:   sel_byte = word[7:0];
            2'b01:   sel_byte = word[15:8];
            2'b10:   sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = addr_q[1] ? word[31:16] : word[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'd0, sel_byte};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = word;
        endcase
        case (funct3_q[1:0])
            2'b00: begin
                store_word = {4{wdata_q[7:0]}};
                lane_en    = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                store_word = {2{wdata_q[15:0]}};
                lane_en    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_word = wdata_q;
                lane_en    = 4'b1111;
            end
        endcase
    end

    // Stores commit only at the end of DONE, so a reset in WAIT drops them.
    always_ff @(posedge clk) begin
        if (state == DONE && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

    assign read_dataM = (state == DONE && !write_q) ? load_val : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors plus randomized
// loads/stores compared against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned NBYTES  = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_reqM, mem_writeM;
    logic [2:0]  funct3M;
    logic [31:0] addrM, write_dataM, read_dataM;
    logic        stallM, doneM, misalignM;

    int checks = 0;
    int errors = 0;
    logic [7:0]  bmem [NBYTES];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .mem_reqM(mem_reqM), .mem_writeM(mem_writeM),
        .funct3M(funct3M), .addrM(addrM), .write_dataM(write_dataM),
        .stallM(stallM), .read_dataM(read_dataM), .doneM(doneM), .misalignM(misalignM)
    );

    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        bit ok_f3;
        ok_f3 = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return ok_f3 && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n, base;
        logic [63:0] v;
        n = m_size(f3);
        base = a % NBYTES;
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (64'(bmem[base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned n, base;
        n = m_size(f3);
        base = a % NBYTES;
        for (int unsigned i = 0; i < n; i++) bmem[base + i] = 8'(d >> (8 * i));
    endtask

    // Drives one request and records what the DUT did; callers do the judging.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int stall_n, output int done_at,
                          output int bad, output logic mis, output logic [31:0] rd);
        stall_n = 0; done_at = -1; bad = 0; mis = 1'b0; rd = 'x;
        @(negedge clk);
        mem_reqM = 1'b1; mem_writeM = wr; funct3M = f3; addrM = a; write_dataM = d;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stallM) stall_n++;
            if (c == 0 && misalignM) begin
                mis = 1'b1;
                if (stallM || doneM) bad++;
                break;
            end
            if (misalignM) bad++;
            if (doneM) begin
                done_at = c;
                rd = read_dataM;
                if (stallM) bad++;
                break;
            end
        end
        @(negedge clk);
        mem_reqM = 1'b0; mem_writeM = 1'($urandom); funct3M = 3'($urandom);
        addrM = $urandom; write_dataM = $urandom;
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_reqM = 1'b0; mem_writeM = 1'b0; funct3M = '0; addrM = '0; write_dataM = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({stallM, doneM, misalignM, read_dataM} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b done=%b mis=%b rd=%h expected all 0",
                     stallM, doneM, misalignM, read_dataM);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_init;
        int sn, da, bad; logic mis; logic [31:0] rd, d;
        for (int unsigned w = 0; w < 16; w++) begin
            d = $urandom;
            access(1'b1, 3'b010, 32'(w * 4), d, sn, da, bad, mis, rd);
            m_store(3'b010, 32'(w * 4), d);
            checks++;
            if (sn !== LATENCY || da !== LATENCY || bad !== 0 || mis !== 1'b0 || rd !== last_rd) begin
                errors++;
                $display("FAIL init_sw[%0d]: got stall=%0d done_at=%0d bad=%0d mis=%b rd=%h expected stall=%0d done_at=%0d bad=0 mis=0 rd=%h",
                         w, sn, da, bad, mis, rd, LATENCY, LATENCY, last_rd);
            end
        end
    endtask

    task automatic test_spec_vectors;
        int sn, da, bad; logic mis; logic [31:0] rd;
        logic [2:0]  vf [6]  = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] va [6]  = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] ve [6]  = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEAD55EF};
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, sn, da, bad, mis, rd);
        m_store(3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if (sn !== 2 || da !== 2 || bad !== 0 || mis !== 1'b0) begin
            errors++;
            $display("FAIL sw_timing: got stall=%0d done_at=%0d bad=%0d expected stall=2 done_at=2 bad=0", sn, da, bad);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                access(1'b1, 3'b000, 32'h11, 32'h00000055, sn, da, bad, mis, rd);
                m_store(3'b000, 32'h11, 32'h00000055);
            end
            access(1'b0, vf[i], va[i], 32'h0, sn, da, bad, mis, rd);
            last_rd = rd;
            checks++;
            if (rd !== ve[i] || rd !== m_load(vf[i], va[i]) || sn !== LATENCY || da !== LATENCY || bad !== 0) begin
                errors++;
                $display("FAIL spec_load[%0d]: got rd=%h stall=%0d done_at=%0d bad=%0d expected rd=%h stall=%0d done_at=%0d",
                         i, rd, sn, da, bad, ve[i], LATENCY, LATENCY);
            end
        end
        #1;
        checks++;
        if (read_dataM !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL rd_hold_idle: got %h expected %h", read_dataM, 32'hDEAD55EF);
        end
        access(1'b1, 3'b001, 32'h2, 32'h0000CAFE, sn, da, bad, mis, rd);
        m_store(3'b001, 32'h2, 32'h0000CAFE);
        #1;
        checks++;
        if (rd !== 32'hDEAD55EF || read_dataM !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL rd_hold_store: got done=%h idle=%h expected %h", rd, read_dataM, 32'hDEAD55EF);
        end
        access(1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5, sn, da, bad, mis, rd);
        m_store(3'b010, 32'h1000, 32'hA5A5A5A5);
        access(1'b0, 3'b010, 32'h0, 32'h0, sn, da, bad, mis, rd);
        last_rd = rd;
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL addr_wrap: got %h expected %h", rd, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_misalign;
        int sn, da, bad; logic mis; logic [31:0] rd;
        logic        iw [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  ifn [8] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b011, 3'b110, 3'b111, 3'b100};
        logic [31:0] ia [8] = '{32'h12, 32'h11, 32'h13, 32'h21, 32'h10, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 8; i++) begin
            access(iw[i], ifn[i], ia[i], 32'h5A5A5A5A, sn, da, bad, mis, rd);
            #1;
            checks++;
            if (mis !== 1'b1 || sn !== 0 || da !== -1 || bad !== 0 || misalignM !== 1'b0) begin
                errors++;
                $display("FAIL misalign[%0d]: got mis=%b stall=%0d done_at=%0d bad=%0d mis_after=%b expected mis=1 stall=0 done_at=-1 bad=0 mis_after=0",
                         i, mis, sn, da, bad, misalignM);
            end
        end
        access(1'b0, 3'b010, 32'h10, 32'h0, sn, da, bad, mis, rd);
        last_rd = rd;
        checks++;
        if (rd !== m_load(3'b010, 32'h10)) begin
            errors++;
            $display("FAIL misalign_mem_intact: got %h expected %h", rd, m_load(3'b010, 32'h10));
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_reqM = 1'b0; mem_writeM = 1'($urandom); funct3M = 3'($urandom);
            addrM = $urandom; write_dataM = $urandom;
            #1;
            checks++;
            if ({stallM, doneM, misalignM} !== 3'b000 || read_dataM !== last_rd) begin
                errors++;
                $display("FAIL idle[%0d]: got stall=%b done=%b mis=%b rd=%h expected 0 0 0 rd=%h",
                         i, stallM, doneM, misalignM, read_dataM, last_rd);
            end
        end
    endtask

    task automatic test_reset_abort;
        int sn, da, bad; logic mis; logic [31:0] rd;
        access(1'b1, 3'b010, 32'h20, 32'h0BADF00D, sn, da, bad, mis, rd);
        m_store(3'b010, 32'h20, 32'h0BADF00D);
        @(negedge clk);
        mem_reqM = 1'b1; mem_writeM = 1'b1; funct3M = 3'b010; addrM = 32'h20; write_dataM = 32'h12345678;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({stallM, doneM, misalignM, read_dataM} !== 35'd0) begin
            errors++;
            $display("FAIL reset_in_wait: got stall=%b done=%b mis=%b rd=%h expected all 0",
                     stallM, doneM, misalignM, read_dataM);
        end
        @(negedge clk);
        mem_reqM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        access(1'b0, 3'b010, 32'h20, 32'h0, sn, da, bad, mis, rd);
        last_rd = rd;
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL reset_abort_store: got %h expected %h", rd, 32'h0BADF00D);
        end
    endtask

    task automatic test_random;
        int sn, da, bad; logic mis; logic [31:0] rd, a, d, exp;
        logic wr; logic [2:0] f3; bit legal;
        logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom);
            f3 = ($urandom_range(0, 3) != 0) ? lf[$urandom_range(0, wr ? 2 : 4)] : 3'($urandom);
            a  = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 1) == 1) a = a & ~32'(m_size(f3) - 1);
            d = $urandom;
            legal = m_legal(wr, f3, a);
            exp = wr ? last_rd : m_load(f3, a);
            access(wr, f3, a, d, sn, da, bad, mis, rd);
            checks++;
            if (legal) begin
                if (wr) m_store(f3, a, d);
                else last_rd = exp;
                if (rd !== exp || sn !== LATENCY || da !== LATENCY || bad !== 0 || mis !== 1'b0) begin
                    errors++;
                    $display("FAIL random[%0d] wr=%b f3=%b a=%h: got rd=%h stall=%0d done_at=%0d bad=%0d mis=%b expected rd=%h stall=%0d done_at=%0d",
                             i, wr, f3, a, rd, sn, da, bad, mis, exp, LATENCY, LATENCY);
                end
            end else if (mis !== 1'b1 || sn !== 0 || da !== -1 || bad !== 0) begin
                errors++;
                $display("FAIL random_illegal[%0d] wr=%b f3=%b a=%h: got mis=%b stall=%0d done_at=%0d expected mis=1 stall=0 done_at=-1",
                         i, wr, f3, a, mis, sn, da);
            end
        end
    endtask

    initial begin
        test_reset;
        test_init;
        test_spec_vectors;
        test_misalign;
        test_idle;
        test_reset_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
